// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory port, the redirect input from execute and
// the valid/ready stream towards decode for the fetch stage.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;
    logic        misalign_err;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output halted,
        output misalign_err
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  halted,
        input  misalign_err
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the fetch PC, buffers fetched words with their PCs
// in a small in-order queue, handles redirects and stops on a halt marker.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] HALT_WORD = 32'hDEAD_BEEF
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t         state, state_next;
    logic [31:0]    fetch_pc;
    logic [31:0]    instr_buf [DEPTH];
    logic [31:0]    pc_buf    [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;

    logic pop_req, pop, space, push, halt_hit;

    always_comb begin
        pop_req  = (count != '0) && bus.out_ready;
        pop      = pop_req && !bus.redirect_valid;
        space    = (count != FULL) || pop_req;
        push     = (state == RUN) && !bus.redirect_valid && space && (bus.imem_rdata != HALT_WORD);
        halt_hit = (state == RUN) && !bus.redirect_valid && space && (bus.imem_rdata == HALT_WORD);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.redirect_valid)
            state_next = RUN;
        else if (halt_hit)
            state_next = HALT;
    end

    // Redirect outranks everything: the buffer is flushed and neither the
    // pending push nor the pending pop takes effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc         <= RESET_PC;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            bus.misalign_err <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            if (bus.redirect_pc[1:0] != 2'b00)
                bus.misalign_err <= 1'b1;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_buf[wr_ptr] <= bus.imem_rdata;
            pc_buf[wr_ptr]    <= fetch_pc;
        end
    end

    always_comb begin
        bus.imem_addr    = fetch_pc;
        bus.out_valid    = (count != '0);
        bus.out_instr    = instr_buf[rd_ptr];
        bus.out_pc       = pc_buf[rd_ptr];
        bus.out_pc_plus4 = pc_buf[rd_ptr] + 32'd4;
        bus.halted       = (state == HALT);
    end
endmodule
